// File: rtl/mem_arbiter_pkg.sv
// Shared defaults and owner encoding for the two-port memory arbiter.
package mem_arbiter_pkg;

   localparam int ADDR_W_DEF       = 12;
   localparam int XLEN_DEF         = 32;
   localparam int READ_LAT_DEF     = 3;
   localparam int STARVE_LIMIT_DEF = 4;

   // Which requester owns an in-flight read.
   typedef enum logic {
      OWN_I = 1'b0,
      OWN_D = 1'b1
   } owner_e;

endpackage

// File: rtl/mem_arb_rd_tracker.sv
// Read tracker: a READ_LAT-deep {valid, owner, addr} shift pipeline whose
// head lines up with the controller's read acknowledge.
module mem_arb_rd_tracker
   import mem_arbiter_pkg::*;
#(
   parameter int ADDR_W   = ADDR_W_DEF,
   parameter int READ_LAT = READ_LAT_DEF
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              push_i,
   input  owner_e            owner_i,
   input  logic [ADDR_W-1:0] addr_i,
   input  logic              ack_i,
   output logic              head_valid_o,
   output owner_e            head_owner_o,
   output logic [ADDR_W-1:0] head_addr_o,
   output logic              err_o
);

   logic [READ_LAT-1:0] vld_q;
   owner_e              own_q [READ_LAT];
   logic [ADDR_W-1:0]   adr_q [READ_LAT];

   // Shift every cycle; stage 0 takes the command issued this cycle.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         vld_q <= '0;
         for (int k = 0; k < READ_LAT; k++) begin
            own_q[k] <= OWN_I;
            adr_q[k] <= '0;
         end
      end else begin
         vld_q[0] <= push_i;
         own_q[0] <= owner_i;
         adr_q[0] <= addr_i;
         for (int k = 1; k < READ_LAT; k++) begin
            vld_q[k] <= vld_q[k-1];
            own_q[k] <= own_q[k-1];
            adr_q[k] <= adr_q[k-1];
         end
      end
   end

   assign head_valid_o = vld_q[READ_LAT-1];
   assign head_owner_o = own_q[READ_LAT-1];
   assign head_addr_o  = adr_q[READ_LAT-1];

   // An ack without a predicted read, or a predicted read without an ack.
   assign err_o = ack_i ^ head_valid_o;

endmodule

// File: rtl/mem_arbiter.sv
// Two-port arbiter sharing one SRAM controller between instruction fetch
// and data load/store. Grants are combinational; the command is registered.
//
// Handshake: a requester raises *_req with its command and holds both
// stable until the matching *_gnt is high in the same cycle; that cycle is
// the transfer. Responses (rvalid/wack) carry no backpressure.
module mem_arbiter
   import mem_arbiter_pkg::*;
#(
   parameter int ADDR_W       = ADDR_W_DEF,
   parameter int XLEN         = XLEN_DEF,
   parameter int READ_LAT     = READ_LAT_DEF,
   parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                i_req,
   input  logic [ADDR_W-1:0]   i_addr,
   output logic                i_gnt,
   output logic                i_rvalid,
   output logic [XLEN-1:0]     i_rdata,
   output logic [ADDR_W-1:0]   i_raddr,
   input  logic                d_req,
   input  logic [ADDR_W-1:0]   d_addr,
   input  logic [XLEN/8-1:0]   d_we,
   input  logic [XLEN-1:0]     d_wdata,
   output logic                d_gnt,
   output logic                d_rvalid,
   output logic [XLEN-1:0]     d_rdata,
   output logic [ADDR_W-1:0]   d_raddr,
   output logic                d_wack,
   output logic [ADDR_W-1:0]   mem_addr,
   output logic                mem_read_en,
   output logic [XLEN/8-1:0]   mem_write_en,
   output logic [XLEN-1:0]     mem_write_data,
   input  logic [XLEN-1:0]     mem_read_data,
   input  logic                mem_read_ack,
   input  logic                mem_write_ack,
   output logic                err
);

   localparam int BE_W  = XLEN / 8;
   localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

   logic [CNT_W-1:0]  starve_q, starve_d;
   logic              fetch_turn;
   logic              d_is_read;

   logic [ADDR_W-1:0] mem_addr_q;
   logic              mem_read_en_q;
   logic [BE_W-1:0]   mem_write_en_q;
   logic [XLEN-1:0]   mem_write_data_q;
   owner_e            mem_owner_q;
   logic              wr_pend_q;
   logic              err_q, err_d;

   logic              head_valid;
   owner_e            head_owner;
   logic [ADDR_W-1:0] head_addr;
   logic              rd_err;

   // Data wins by default; fetch takes the slot once it has watched
   // STARVE_LIMIT data grants go by while it was waiting.
   assign fetch_turn = i_req && (starve_q == CNT_W'(STARVE_LIMIT));
   assign d_gnt      = d_req && !fetch_turn;
   assign i_gnt      = i_req && !d_gnt;
   assign d_is_read  = (d_we == '0);

   // Starvation counter next state.
   always_comb begin
      starve_d = starve_q;
      if (!i_req || i_gnt) begin
         starve_d = '0;
      end else if (d_gnt) begin
         starve_d = starve_q + CNT_W'(1);
      end
   end

   // Command register: strobes are single-cycle pulses, zero without a grant.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         starve_q         <= '0;
         mem_addr_q       <= '0;
         mem_read_en_q    <= 1'b0;
         mem_write_en_q   <= '0;
         mem_write_data_q <= '0;
         mem_owner_q      <= OWN_I;
      end else begin
         starve_q         <= starve_d;
         mem_read_en_q    <= i_gnt || (d_gnt && d_is_read);
         mem_write_en_q   <= d_gnt ? d_we : '0;
         mem_write_data_q <= (d_gnt && !d_is_read) ? d_wdata : '0;
         if (i_gnt) begin
            mem_addr_q  <= i_addr;
            mem_owner_q <= OWN_I;
         end else if (d_gnt) begin
            mem_addr_q  <= d_addr;
            mem_owner_q <= OWN_D;
         end
      end
   end

   // Each issued read enters the tracker the cycle its strobe is on the bus.
   mem_arb_rd_tracker #(
      .ADDR_W   (ADDR_W),
      .READ_LAT (READ_LAT)
   ) u_rd_tracker (
      .clk          (clk),
      .reset        (reset),
      .push_i       (mem_read_en_q),
      .owner_i      (mem_owner_q),
      .addr_i       (mem_addr_q),
      .ack_i        (mem_read_ack),
      .head_valid_o (head_valid),
      .head_owner_o (head_owner),
      .head_addr_o  (head_addr),
      .err_o        (rd_err)
   );

   // Sticky error: any read or write ack that the trackers did not predict.
   always_comb begin
      err_d = err_q || rd_err || (mem_write_ack ^ wr_pend_q);
   end

   // Write-pending flag (one cycle behind the strobe) and the error latch.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_pend_q <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         wr_pend_q <= |mem_write_en_q;
         err_q     <= err_d;
      end
   end

   assign mem_addr       = mem_addr_q;
   assign mem_read_en    = mem_read_en_q;
   assign mem_write_en   = mem_write_en_q;
   assign mem_write_data = mem_write_data_q;
   assign err            = err_q;

   assign i_rvalid = mem_read_ack && head_valid && (head_owner == OWN_I);
   assign d_rvalid = mem_read_ack && head_valid && (head_owner == OWN_D);
   assign i_rdata  = mem_read_data;
   assign d_rdata  = mem_read_data;
   assign i_raddr  = head_addr;
   assign d_raddr  = head_addr;
   assign d_wack   = mem_write_ack && wr_pend_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: SRAM controller model, per-cycle driver,
// scoreboard queues for commands, read responses and write acks.
module tb_mem_arbiter;
   import mem_arbiter_pkg::*;

   localparam int AW    = 12;
   localparam int XW    = 32;
   localparam int BW    = XW / 8;
   localparam int LAT   = 3;
   localparam int RSP_W = 16 + 1 + AW + XW;
   localparam int CMD_W = 16 + 1 + BW + AW + XW;
   localparam int DC_W  = BW + AW + XW;

   logic          clk, reset;
   logic          i_req, i_gnt, i_rvalid;
   logic [AW-1:0] i_addr, i_raddr;
   logic [XW-1:0] i_rdata;
   logic          d_req, d_gnt, d_rvalid, d_wack;
   logic [AW-1:0] d_addr, d_raddr;
   logic [BW-1:0] d_we;
   logic [XW-1:0] d_wdata, d_rdata;
   logic [AW-1:0] mem_addr;
   logic          mem_read_en, mem_read_ack, mem_write_ack;
   logic [BW-1:0] mem_write_en;
   logic [XW-1:0] mem_write_data, mem_read_data;
   logic          err;

   // scoreboard state
   logic [RSP_W-1:0] exp_q[$];
   logic [CMD_W-1:0] cmd_q[$];
   logic [15:0]      wack_q[$];
   logic [AW-1:0]    fq[$];
   logic [DC_W-1:0]  dq[$];
   logic [XW-1:0]    ref_mem [1 << AW];
   int               n_cmp, n_bad;
   logic [15:0]      cyc;
   logic             exp_err;
   logic             inject_ack;
   logic             last_i, last_d;

   // controller model state
   logic [XW-1:0]  ctrl_mem [1 << AW];
   logic [LAT-1:0] rd_v;
   logic [XW-1:0]  rd_d [LAT];
   logic           wack_r;

   mem_arbiter #(
      .ADDR_W       (AW),
      .XLEN         (XW),
      .READ_LAT     (LAT),
      .STARVE_LIMIT (4)
   ) dut (
      .clk            (clk),
      .reset          (reset),
      .i_req          (i_req),
      .i_addr         (i_addr),
      .i_gnt          (i_gnt),
      .i_rvalid       (i_rvalid),
      .i_rdata        (i_rdata),
      .i_raddr        (i_raddr),
      .d_req          (d_req),
      .d_addr         (d_addr),
      .d_we           (d_we),
      .d_wdata        (d_wdata),
      .d_gnt          (d_gnt),
      .d_rvalid       (d_rvalid),
      .d_rdata        (d_rdata),
      .d_raddr        (d_raddr),
      .d_wack         (d_wack),
      .mem_addr       (mem_addr),
      .mem_read_en    (mem_read_en),
      .mem_write_en   (mem_write_en),
      .mem_write_data (mem_write_data),
      .mem_read_data  (mem_read_data),
      .mem_read_ack   (mem_read_ack),
      .mem_write_ack  (mem_write_ack),
      .err            (err)
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 16'd1;

   function automatic logic [XW-1:0] init_word(input logic [AW-1:0] a);
      if (a == 12'h010) return 32'hDEAD_BEEF;
      if (a == 12'h020) return 32'hAAAA_AAAA;
      return 32'h5A00_0000 ^ (32'(a) * 32'h0000_9E37);
   endfunction

   function automatic logic [XW-1:0] merge(input logic [XW-1:0] old,
                                           input logic [BW-1:0] we,
                                           input logic [XW-1:0] wd);
      logic [XW-1:0] r;
      for (int b = 0; b < BW; b++) r[8*b +: 8] = we[b] ? wd[8*b +: 8] : old[8*b +: 8];
      return r;
   endfunction

   // ---------------- SRAM controller model ----------------
   initial begin
      for (int a = 0; a < (1 << AW); a++) ctrl_mem[a] <= init_word(AW'(a));
   end

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         rd_v   <= '0;
         wack_r <= 1'b0;
         for (int k = 0; k < LAT; k++) rd_d[k] <= '0;
      end else begin
         rd_v    <= {rd_v[LAT-2:0], mem_read_en};
         rd_d[0] <= ctrl_mem[mem_addr];
         for (int k = 1; k < LAT; k++) rd_d[k] <= rd_d[k-1];
         wack_r  <= |mem_write_en;
         if (|mem_write_en) ctrl_mem[mem_addr] <= merge(ctrl_mem[mem_addr], mem_write_en, mem_write_data);
      end
   end

   assign mem_read_ack  = rd_v[LAT-1] | inject_ack;
   assign mem_read_data = rd_d[LAT-1];
   assign mem_write_ack = wack_r;

   // ---------------- checking ----------------
   task automatic chk(input string tag, input logic [79:0] got, input logic [79:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   // Compare everything the DUT shows in the current cycle against the queues.
   task automatic monitor();
      logic [RSP_W-1:0] e;
      logic [CMD_W-1:0] c;
      if (cmd_q.size() > 0 && cmd_q[0][CMD_W-1 -: 16] == cyc) begin
         c = cmd_q.pop_front();
         chk("mem_cmd", {mem_read_en, mem_write_en, mem_addr, mem_write_data}, c[CMD_W-17:0]);
      end else begin
         chk("mem_idle", {mem_read_en, mem_write_en}, '0);
      end
      if (exp_q.size() > 0 && exp_q[0][RSP_W-1 -: 16] == cyc) begin
         e = exp_q.pop_front();
         if (e[AW+XW] == OWN_I)
            chk("i_rsp", {i_rvalid, d_rvalid, i_raddr, i_rdata}, {2'b10, e[AW+XW-1:0]});
         else
            chk("d_rsp", {i_rvalid, d_rvalid, d_raddr, d_rdata}, {2'b01, e[AW+XW-1:0]});
      end else begin
         chk("rvalid_idle", {i_rvalid, d_rvalid}, '0);
      end
      if (wack_q.size() > 0 && wack_q[0] == cyc) begin
         void'(wack_q.pop_front());
         chk("d_wack", d_wack, 1);
      end else begin
         chk("d_wack_idle", d_wack, 0);
      end
      chk("err", err, exp_err);
   endtask

   // ---------------- driver ----------------
   // One clock cycle: check outputs, present queue heads, record grants.
   task automatic step(input bit ai, input bit ad, input bit inj);
      logic [AW-1:0] fa;
      logic [BW-1:0] we;
      logic [AW-1:0] da;
      logic [XW-1:0] wd;
      @(posedge clk);
      #2;
      monitor();
      inject_ack = inj;
      i_req  = ai && (fq.size() > 0);
      i_addr = i_req ? fq[0] : '0;
      d_req  = ad && (dq.size() > 0);
      {we, da, wd} = d_req ? dq[0] : '0;
      d_we    = we;
      d_addr  = da;
      d_wdata = wd;
      #1;
      chk("gnt_excl", i_gnt & d_gnt, 0);
      last_i = i_gnt;
      last_d = d_gnt;
      if (i_gnt) begin
         fa = fq.pop_front();
         cmd_q.push_back({cyc + 16'd1, 1'b1, {BW{1'b0}}, fa, {XW{1'b0}}});
         exp_q.push_back({cyc + 16'd4, OWN_I, fa, ref_mem[fa]});
      end
      if (d_gnt) begin
         void'(dq.pop_front());
         if (we == '0) begin
            cmd_q.push_back({cyc + 16'd1, 1'b1, {BW{1'b0}}, da, {XW{1'b0}}});
            exp_q.push_back({cyc + 16'd4, OWN_D, da, ref_mem[da]});
         end else begin
            cmd_q.push_back({cyc + 16'd1, 1'b0, we, da, wd});
            ref_mem[da] = merge(ref_mem[da], we, wd);
            wack_q.push_back(cyc + 16'd2);
         end
      end
   endtask

   task automatic drain();
      for (int n = 0; n < 24 && (exp_q.size() + cmd_q.size() + wack_q.size() +
                                 fq.size() + dq.size()) > 0; n++)
         step(1'b1, 1'b1, 1'b0);
      step(1'b0, 1'b0, 1'b0);
   endtask

   task automatic do_reset();
      i_req = 1'b0;
      d_req = 1'b0;
      inject_ack = 1'b0;
      reset = 1'b1;
      #1;
      chk("rst_mem_addr", mem_addr, 0);
      chk("rst_strobes", {mem_read_en, mem_write_en}, 0);
      chk("rst_wdata", mem_write_data, 0);
      chk("rst_err", err, 0);
      chk("rst_resp", {i_rvalid, d_rvalid, d_wack}, 0);
      exp_q.delete();
      cmd_q.delete();
      wack_q.delete();
      exp_err = 1'b0;
      @(posedge clk);
      #2;
      reset = 1'b0;
   endtask

   // ---------------- stimulus ----------------
   logic [11:0] pat;
   int          n_gnt;

   initial begin
      n_cmp = 0; n_bad = 0; cyc = '0; exp_err = 1'b0; inject_ack = 1'b0;
      reset = 1'b0; i_req = 1'b0; i_addr = '0; d_req = 1'b0; d_addr = '0;
      d_we = '0; d_wdata = '0; last_i = 1'b0; last_d = 1'b0;
      for (int a = 0; a < (1 << AW); a++) ref_mem[a] = init_word(AW'(a));
      #3;
      do_reset();

      // single fetch read of 0x010
      fq.push_back(12'h010);
      step(1'b1, 1'b0, 1'b0);
      chk("fetch_gnt", last_i, 1);
      drain();

      // store then load at 0x020: low half replaced
      dq.push_back({4'b0011, 12'h020, 32'h1234_5678});
      dq.push_back({4'b0000, 12'h020, 32'h0000_0000});
      drain();
      chk("merged_word", ref_mem[12'h020], 32'hAAAA_5678);

      // both ports continuously busy: DDDDI DDDDI DD
      fq.push_back(12'($urandom_range(0, 7)));
      fq.push_back(12'($urandom_range(0, 7)));
      for (int k = 0; k < 10; k++)
         dq.push_back({($urandom_range(0, 1) == 1) ? 4'($urandom_range(1, 15)) : 4'h0,
                       12'($urandom_range(0, 7)), 32'($urandom)});
      pat = '0;
      n_gnt = 0;
      for (int k = 0; k < 12; k++) begin
         step(1'b1, 1'b1, 1'b0);
         pat[k] = last_i;
         n_gnt += int'(last_i) + int'(last_d);
      end
      chk("starve_pattern", pat, 12'b0010_0001_0000);
      chk("grant_count", n_gnt, 12);
      drain();

      // interleaved reads I@1, D@2, I@3
      fq.push_back(12'd1);
      fq.push_back(12'd3);
      dq.push_back({4'b0000, 12'd2, 32'd0});
      step(1'b1, 1'b0, 1'b0);
      step(1'b0, 1'b1, 1'b0);
      step(1'b1, 1'b0, 1'b0);
      drain();

      // spurious read ack on an empty pipeline: err is sticky
      step(1'b0, 1'b0, 1'b1);
      exp_err = 1'b1;
      for (int k = 0; k < 5; k++) step(1'b0, 1'b0, 1'b0);
      do_reset();

      // reset with three reads in flight
      fq.push_back(12'h030);
      fq.push_back(12'h031);
      fq.push_back(12'h032);
      for (int k = 0; k < 3; k++) step(1'b1, 1'b0, 1'b0);
      do_reset();
      for (int k = 0; k < 8; k++) step(1'b0, 1'b0, 1'b0);

      drain();
      chk("queues_empty", exp_q.size() + cmd_q.size() + wack_q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

endmodule
